// File: rtl/life_pkg.sv
// Shared definitions for the life array readout path: the width helper and
// the frame scanner state encoding.
package life_pkg;

    // Frame scanner states: waiting, streaming cells, closing the frame.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_e;

    // Bits needed to index n distinct values, never less than one bit so a
    // 1-wide array still gets a usable index port.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if (int'(32'd1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/life_rc_counter.sv
// Row/column walker for the frame scanner. Visits cells in row-major order
// and flags the final cell (ROWS-1, COLS-1) with a registered last bit.
module life_rc_counter
    import life_pkg::*;
#(
    parameter int ROWS = 16,
    parameter int COLS = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clr_i,
    input  logic                          adv_i,
    output logic [clog2_min1(ROWS)-1:0]   row_o,
    output logic [clog2_min1(COLS)-1:0]   col_o,
    output logic                          last_o
);

    localparam int RW = clog2_min1(ROWS);
    localparam int CW = clog2_min1(COLS);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
    localparam logic ONE_CELL = ((ROWS * COLS) == 1) ? 1'b1 : 1'b0;

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          last_q, last_d;

    // Next position: clear to the origin, or step one cell with column wrap.
    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        last_d = last_q;
        if (clr_i) begin
            row_d  = {RW{1'b0}};
            col_d  = {CW{1'b0}};
            last_d = ONE_CELL;
        end else if (adv_i) begin
            if (last_q) begin
                // Stepping past the final cell parks the walker at the origin.
                row_d  = {RW{1'b0}};
                col_d  = {CW{1'b0}};
                last_d = 1'b0;
            end else begin
                if (col_q == COL_MAX) begin
                    col_d = {CW{1'b0}};
                    row_d = row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                    row_d = row_q;
                end
                last_d = (row_d == ROW_MAX) && (col_d == COL_MAX);
            end
        end else begin
            row_d  = row_q;
            col_d  = col_q;
            last_d = last_q;
        end
    end

    // Position registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q  <= {RW{1'b0}};
            col_q  <= {CW{1'b0}};
            last_q <= 1'b0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            last_q <= last_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = last_q;

endmodule

// File: rtl/life_frame_scanner.sv
// Readout stage for the life cell array: snapshots the alive/previous planes
// on start, streams one cell per valid/ready transfer in row-major order and
// publishes population and change counts when the frame closes.
module life_frame_scanner
    import life_pkg::*;
#(
    parameter int ROWS = 16,
    parameter int COLS = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [ROWS*COLS-1:0]                  alive_vec,
    input  logic [ROWS*COLS-1:0]                  prev_vec,
    input  logic                                  start,
    input  logic                                  out_ready,
    output logic                                  out_valid,
    output logic                                  out_alive,
    output logic                                  out_changed,
    output logic [clog2_min1(ROWS)-1:0]           out_row,
    output logic [clog2_min1(COLS)-1:0]           out_col,
    output logic                                  out_last,
    output logic                                  busy,
    output logic                                  frame_done,
    output logic [clog2_min1(ROWS*COLS+1)-1:0]    live_count,
    output logic [clog2_min1(ROWS*COLS+1)-1:0]    change_count,
    output logic                                  stable
);

    localparam int N  = ROWS * COLS;
    localparam int SW = clog2_min1(N + 1);

    scan_state_e   state_q, state_d;
    logic [N-1:0]  alive_snap_q;
    logic [N-1:0]  chg_snap_q;
    logic          valid_q, busy_q, done_q;
    logic [SW-1:0] live_acc_q, chg_acc_q;
    logic [SW-1:0] live_cnt_q, chg_cnt_q;
    logic          stable_q;

    logic          xfer_s, capture_s, finish_s, last_s;
    logic [SW-1:0] live_sum_s, chg_sum_s;

    // The snapshot is consumed as a shift register, so bit 0 is always the
    // presented cell and the cell outputs come straight from flops.
    assign xfer_s     = valid_q & out_ready;
    assign live_sum_s = live_acc_q + SW'(alive_snap_q[0]);
    assign chg_sum_s  = chg_acc_q + SW'(chg_snap_q[0]);

    life_rc_counter #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_rc (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (capture_s),
        .adv_i  (xfer_s),
        .row_o  (out_row),
        .col_o  (out_col),
        .last_o (last_s)
    );

    // Frame sequencing; start only matters while idle and is never queued.
    always_comb begin
        state_d   = state_q;
        capture_s = 1'b0;
        finish_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SCAN;
                    capture_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (xfer_s && last_s) begin
                    state_d  = ST_DONE;
                    finish_s = 1'b1;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register and the handshake/status flags derived from next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d == ST_SCAN);
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    // Snapshot capture on start, then shift one cell out per transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alive_snap_q <= {N{1'b0}};
            chg_snap_q   <= {N{1'b0}};
        end else if (capture_s) begin
            alive_snap_q <= alive_vec;
            chg_snap_q   <= alive_vec ^ prev_vec;
        end else if (xfer_s) begin
            alive_snap_q <= alive_snap_q >> 1;
            chg_snap_q   <= chg_snap_q >> 1;
        end else begin
            alive_snap_q <= alive_snap_q;
            chg_snap_q   <= chg_snap_q;
        end
    end

    // Running per-frame accumulators over transferred cells.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live_acc_q <= {SW{1'b0}};
            chg_acc_q  <= {SW{1'b0}};
        end else if (capture_s) begin
            live_acc_q <= {SW{1'b0}};
            chg_acc_q  <= {SW{1'b0}};
        end else if (xfer_s) begin
            live_acc_q <= live_sum_s;
            chg_acc_q  <= chg_sum_s;
        end else begin
            live_acc_q <= live_acc_q;
            chg_acc_q  <= chg_acc_q;
        end
    end

    // Published statistics, folded in with the final cell on entry to DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live_cnt_q <= {SW{1'b0}};
            chg_cnt_q  <= {SW{1'b0}};
            stable_q   <= 1'b0;
        end else if (finish_s) begin
            live_cnt_q <= live_sum_s;
            chg_cnt_q  <= chg_sum_s;
            stable_q   <= (chg_sum_s == {SW{1'b0}});
        end else begin
            live_cnt_q <= live_cnt_q;
            chg_cnt_q  <= chg_cnt_q;
            stable_q   <= stable_q;
        end
    end

    assign out_valid    = valid_q;
    assign out_alive    = alive_snap_q[0];
    assign out_changed  = chg_snap_q[0];
    assign out_last     = last_s;
    assign busy         = busy_q;
    assign frame_done   = done_q;
    assign live_count   = live_cnt_q;
    assign change_count = chg_cnt_q;
    assign stable       = stable_q;

endmodule

// File: tb/tb_life_frame_scanner.sv
// Scoreboard bench for life_frame_scanner on a 4x4 array.
module tb_life_frame_scanner;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int N    = ROWS * COLS;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  alive_vec, prev_vec;
    logic          start, out_ready;
    logic          out_valid, out_alive, out_changed, out_last;
    logic [1:0]    out_row, out_col;
    logic          busy, frame_done, stable;
    logic [4:0]    live_count, change_count;

    typedef struct packed {
        logic       alive;
        logic       changed;
        logic [1:0] row;
        logic [1:0] col;
        logic       last;
    } cell_t;

    cell_t exp_q[$];
    cell_t obs_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    int    done_cyc, done_cnt, stall_breaks;
    bit    timed_out;
    int    ref_live, ref_chg;

    life_frame_scanner #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk          (clk),
        .reset        (reset),
        .alive_vec    (alive_vec),
        .prev_vec     (prev_vec),
        .start        (start),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_alive    (out_alive),
        .out_changed  (out_changed),
        .out_row      (out_row),
        .out_col      (out_col),
        .out_last     (out_last),
        .busy         (busy),
        .frame_done   (frame_done),
        .live_count   (live_count),
        .change_count (change_count),
        .stable       (stable)
    );

    always #5 clk = ~clk;

    // Expected stream for a frame, pushed when the frame is requested.
    task automatic push_expected(input logic [N-1:0] a, input logic [N-1:0] p);
        for (int i = 0; i < N; i++) begin
            cell_t c;
            c.alive   = a[i];
            c.changed = a[i] ^ p[i];
            c.row     = 2'(i / COLS);
            c.col     = 2'(i % COLS);
            c.last    = (i == N - 1);
            exp_q.push_back(c);
        end
    endtask

    // Request a frame; returns just after the capture edge.
    task automatic start_frame(input logic [N-1:0] a, input logic [N-1:0] p);
        alive_vec = a;
        prev_vec  = p;
        start     = 1'b1;
        push_expected(a, p);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Consume the stream into obs_q and record frame timing and stall behaviour.
    task automatic drain_frame(input int ready_pct, input bit wiggle, input bit hold_start,
                               output int d_cyc, output int d_cnt, output int s_breaks,
                               output bit t_out);
        logic [7:0] saved;
        bit stalled;
        d_cyc = -1; d_cnt = 0; s_breaks = 0; t_out = 1'b1; stalled = 1'b0; saved = 8'd0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (stalled && ({out_valid, out_alive, out_changed, out_row, out_col, out_last} !== saved))
                s_breaks++;
            if (frame_done === 1'b1) begin
                d_cnt++;
                if (d_cyc < 0) d_cyc = cyc;
            end
            if (cyc > 0 && busy === 1'b0) begin
                t_out = 1'b0;
                start = 1'b0;
                break;
            end
            out_ready = (int'($urandom_range(0, 99)) < ready_pct);
            if (wiggle) begin
                alive_vec = 16'($urandom);
                prev_vec  = 16'($urandom);
            end
            if (hold_start) start = 1'b1;
            if (out_valid === 1'b1 && out_ready) begin
                obs_q.push_back({out_alive, out_changed, out_row, out_col, out_last});
                stalled = 1'b0;
            end else if (out_valid === 1'b1) begin
                saved   = {out_valid, out_alive, out_changed, out_row, out_col, out_last};
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        alive_vec = 16'h0000; prev_vec = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({out_valid, out_alive, out_changed, out_row, out_col, out_last, busy, frame_done,
             live_count, change_count, stable} !== 21'd0) begin
            miscompares++;
            $display("FAIL reset_outputs actual valid=%b busy=%b done=%b live=%0d chg=%0d required all 0",
                     out_valid, busy, frame_done, live_count, change_count);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if ({busy, out_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL idle_after_reset actual busy=%b valid=%b required 0 0", busy, out_valid);
        end
    endtask

    task automatic test_glider();
        cell_t e, o;
        start_frame(16'h0742, 16'h0000);
        vectors++;
        if ({busy, out_valid, out_row, out_col} !== 6'b110000) begin
            miscompares++;
            $display("FAIL glider_first_cell actual busy=%b valid=%b r=%0d c=%0d required 1 1 0 0",
                     busy, out_valid, out_row, out_col);
        end
        drain_frame(100, 1'b0, 1'b0, done_cyc, done_cnt, stall_breaks, timed_out);
        vectors++;
        if (timed_out !== 1'b0 || done_cyc !== N || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL glider_timing actual timeout=%b done_cyc=%0d pulses=%0d required 0 %0d 1",
                     timed_out, done_cyc, done_cnt, N);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL glider_cell actual=%h required=%h", o, e);
            end
        end
        obs_q.delete();
        vectors++;
        if (live_count !== 5'd5 || change_count !== 5'd5 || stable !== 1'b0) begin
            miscompares++;
            $display("FAIL glider_counts actual live=%0d chg=%0d stable=%b required 5 5 0",
                     live_count, change_count, stable);
        end
    endtask

    task automatic test_stable();
        cell_t e, o;
        start_frame(16'h0070, 16'h0070);
        drain_frame(100, 1'b0, 1'b0, done_cyc, done_cnt, stall_breaks, timed_out);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL stable_cell actual=%h required=%h", o, e);
            end
        end
        obs_q.delete();
        vectors++;
        if (timed_out !== 1'b0 || live_count !== 5'd3 || change_count !== 5'd0 || stable !== 1'b1) begin
            miscompares++;
            $display("FAIL stable_counts actual live=%0d chg=%0d stable=%b required 3 0 1",
                     live_count, change_count, stable);
        end
        start_frame(16'h0070, 16'h0222);
        drain_frame(100, 1'b0, 1'b0, done_cyc, done_cnt, stall_breaks, timed_out);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL change4_cell actual=%h required=%h", o, e);
            end
        end
        obs_q.delete();
        vectors++;
        if (timed_out !== 1'b0 || live_count !== 5'd3 || change_count !== 5'd4 || stable !== 1'b0) begin
            miscompares++;
            $display("FAIL change4_counts actual live=%0d chg=%0d stable=%b required 3 4 0",
                     live_count, change_count, stable);
        end
    endtask

    task automatic test_random_ready();
        cell_t e, o;
        start_frame(16'h0742, 16'h0000);
        drain_frame(50, 1'b0, 1'b0, done_cyc, done_cnt, stall_breaks, timed_out);
        vectors++;
        if (timed_out !== 1'b0 || stall_breaks !== 0 || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL backpressure_hold actual timeout=%b stall_changes=%0d pulses=%0d required 0 0 1",
                     timed_out, stall_breaks, done_cnt);
        end
        vectors++;
        if (obs_q.size() !== N) begin
            miscompares++;
            $display("FAIL backpressure_count actual=%0d required=%0d", obs_q.size(), N);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL backpressure_cell actual=%h required=%h", o, e);
            end
        end
        obs_q.delete();
        vectors++;
        if (live_count !== 5'd5 || change_count !== 5'd5) begin
            miscompares++;
            $display("FAIL backpressure_counts actual live=%0d chg=%0d required 5 5", live_count, change_count);
        end
    endtask

    task automatic test_no_tearing();
        cell_t e, o;
        logic [N-1:0] a, p;
        a = 16'hA5C3; p = 16'h3C96;
        ref_live = $countones(a);
        ref_chg  = $countones(a ^ p);
        start_frame(a, p);
        drain_frame(70, 1'b1, 1'b0, done_cyc, done_cnt, stall_breaks, timed_out);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL tearing_cell actual=%h required=%h", o, e);
            end
        end
        obs_q.delete();
        vectors++;
        if (timed_out !== 1'b0 || int'(live_count) !== ref_live || int'(change_count) !== ref_chg) begin
            miscompares++;
            $display("FAIL tearing_counts actual live=%0d chg=%0d required %0d %0d",
                     live_count, change_count, ref_live, ref_chg);
        end
    endtask

    task automatic test_start_ignored();
        cell_t e, o;
        start_frame(16'h0742, 16'h0070);
        drain_frame(100, 1'b0, 1'b1, done_cyc, done_cnt, stall_breaks, timed_out);
        vectors++;
        if (timed_out !== 1'b0 || done_cnt !== 1 || done_cyc !== N) begin
            miscompares++;
            $display("FAIL start_ignored actual timeout=%b pulses=%0d done_cyc=%0d required 0 1 %0d",
                     timed_out, done_cnt, done_cyc, N);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL start_ignored_cell actual=%h required=%h", o, e);
            end
        end
        obs_q.delete();
        // busy has just fallen: a start now must be taken.
        start_frame(16'h0001, 16'h0000);
        vectors++;
        if ({busy, out_valid} !== 2'b11) begin
            miscompares++;
            $display("FAIL restart_accept actual busy=%b valid=%b required 1 1", busy, out_valid);
        end
        drain_frame(100, 1'b0, 1'b0, done_cyc, done_cnt, stall_breaks, timed_out);
        obs_q.delete();
        exp_q.delete();
        vectors++;
        if (timed_out !== 1'b0 || live_count !== 5'd1 || change_count !== 5'd1) begin
            miscompares++;
            $display("FAIL restart_counts actual live=%0d chg=%0d required 1 1", live_count, change_count);
        end
    endtask

    task automatic test_async_reset();
        cell_t e, o;
        start_frame(16'hFFFF, 16'h0F0F);
        out_ready = 1'b1;
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        vectors++;
        if ({out_valid, out_row, out_col} !== 5'b1_01_11) begin
            miscompares++;
            $display("FAIL abort_position actual valid=%b r=%0d c=%0d required 1 1 3", out_valid, out_row, out_col);
        end
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if ({out_valid, out_alive, out_changed, out_row, out_col, out_last, busy, frame_done,
             live_count, change_count, stable} !== 21'd0) begin
            miscompares++;
            $display("FAIL async_reset actual valid=%b alive=%b r=%0d c=%0d busy=%b live=%0d required all 0",
                     out_valid, out_alive, out_row, out_col, busy, live_count);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({frame_done, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL abort_no_done actual done=%b busy=%b required 0 0", frame_done, busy);
        end
        reset = 1'b0;
        exp_q.delete();
        obs_q.delete();
        @(posedge clk);
        #1;
        start_frame(16'hFFFF, 16'h0F0F);
        drain_frame(100, 1'b0, 1'b0, done_cyc, done_cnt, stall_breaks, timed_out);
        vectors++;
        if (timed_out !== 1'b0 || done_cnt !== 1 || done_cyc !== N) begin
            miscompares++;
            $display("FAIL post_reset_frame actual timeout=%b pulses=%0d done_cyc=%0d required 0 1 %0d",
                     timed_out, done_cnt, done_cyc, N);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL post_reset_cell actual=%h required=%h", o, e);
            end
        end
        obs_q.delete();
        vectors++;
        if (live_count !== 5'd16 || change_count !== 5'd8 || stable !== 1'b0) begin
            miscompares++;
            $display("FAIL full_alive_counts actual live=%0d chg=%0d stable=%b required 16 8 0",
                     live_count, change_count, stable);
        end
    endtask

    initial begin
        test_reset();
        test_glider();
        test_stable();
        test_random_ready();
        test_no_tearing();
        test_start_ignored();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
